// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// register-index width and the source/destination register match helper.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned RegIdxW = 5;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StDmemWait = 2'd1,
        StError    = 2'd2
    } state_e;

    // True when the destination matches a source the ID instruction actually reads.
    function automatic logic reg_match(
        input logic [RegIdxW-1:0] rd,
        input logic [RegIdxW-1:0] rs,
        input logic [RegIdxW-1:0] rt,
        input logic               uses_rt
    );
        return (rd == rs) || (uses_rt && (rd == rt));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational data-hazard detection. Define HAZARD_FORWARDING_EN for the
// load-use-only rule; otherwise any pending EX/MEM register write stalls.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [RegIdxW-1:0] id_rs_i,
    input  logic [RegIdxW-1:0] id_rt_i,
    input  logic               id_uses_rt_i,
    input  logic               ex_mem_read_i,
    input  logic               ex_reg_write_i,
    input  logic [RegIdxW-1:0] ex_rd_i,
    input  logic               mem_reg_write_i,
    input  logic [RegIdxW-1:0] mem_rd_i,
    output logic               hazard_o
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = reg_match(ex_rd_i, id_rs_i, id_rt_i, id_uses_rt_i);
    assign mem_match = reg_match(mem_rd_i, id_rs_i, id_rt_i, id_uses_rt_i);

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers ALU results; only a load in EX cannot be bypassed in time.
    logic unused_fwd;
    assign unused_fwd = ^{ex_reg_write_i, mem_reg_write_i, mem_match};
    assign hazard_o   = ex_mem_read_i && (ex_rd_i != '0) && ex_match;
`else
    logic unused_nofwd;
    assign unused_nofwd = ex_mem_read_i;
    assign hazard_o = (ex_reg_write_i && (ex_rd_i != '0) && ex_match) ||
                      (mem_reg_write_i && (mem_rd_i != '0) && mem_match);
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: DMEM wait/timeout FSM, branch flush, data-hazard
// stalls and a saturating stall counter. Hazard rule set by HAZARD_FORWARDING_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [RegIdxW-1:0]     ID_Rs,
    input  logic [RegIdxW-1:0]     ID_Rt,
    input  logic                   ID_UsesRt,
    input  logic                   EX_MemRead,
    input  logic                   EX_RegWrite,
    input  logic [RegIdxW-1:0]     EX_Rd,
    input  logic                   MEM_RegWrite,
    input  logic [RegIdxW-1:0]     MEM_Rd,
    input  logic                   EX_BranchTaken,
    input  logic                   DMEM_Req,
    input  logic                   DMEM_Ack,
    output logic                   PC_Write,
    output logic                   IF_ID_Stall,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Bubble,
    output logic                   EX_MEM_Hold,
    output logic                   Mem_Timeout,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT);

    state_e                 state_q, state_d;
    logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [WaitW-1:0]       wait_inc;
    logic                   timeout_q, timeout_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   mem_hold;
    logic                   hazard;

    hazard_detect u_hazard_detect (
        .id_rs_i        (ID_Rs),
        .id_rt_i        (ID_Rt),
        .id_uses_rt_i   (ID_UsesRt),
        .ex_mem_read_i  (EX_MemRead),
        .ex_reg_write_i (EX_RegWrite),
        .ex_rd_i        (EX_Rd),
        .mem_reg_write_i(MEM_RegWrite),
        .mem_rd_i       (MEM_Rd),
        .hazard_o       (hazard)
    );

    assign wait_inc = wait_cnt_q + WaitW'(1);

    // wait_cnt counts held cycles, including the RUN cycle that raised the request.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        mem_hold   = 1'b0;
        case (state_q)
            StRun: begin
                if (DMEM_Req && !DMEM_Ack) begin
                    mem_hold   = 1'b1;
                    wait_cnt_d = WaitW'(1);
                    if (WaitLimit <= WaitW'(1)) begin
                        state_d   = StError;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = StDmemWait;
                    end
                end
            end
            StDmemWait: begin
                if (DMEM_Ack) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    mem_hold   = 1'b1;
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= WaitLimit) begin
                        state_d   = StError;
                        timeout_d = 1'b1;
                    end
                end
            end
            StError: begin
                mem_hold = 1'b1;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Stall  = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        EX_MEM_Hold  = 1'b0;
        if (!RESET) begin
            PC_Write     = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (mem_hold) begin
            PC_Write    = 1'b0;
            IF_ID_Stall = 1'b1;
            EX_MEM_Hold = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (hazard) begin
            PC_Write     = 1'b0;
            IF_ID_Stall  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            if (!PC_Write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end
    end

    assign Mem_Timeout = timeout_q;
    assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (4-bit stall counter,
// MEM_TIMEOUT=8 so timeout and saturation are reachable).
module tb_pipeline_hazard_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [4:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
    logic       ID_UsesRt, EX_MemRead, EX_RegWrite, MEM_RegWrite;
    logic       EX_BranchTaken, DMEM_Req, DMEM_Ack;
    logic       PC_Write, IF_ID_Stall, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Hold;
    logic       Mem_Timeout;
    logic [3:0] Stall_Count;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_hazard_ctrl #(
        .STALL_CNT_W(4),
        .MEM_TIMEOUT(8)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_UsesRt     (ID_UsesRt),
        .EX_MemRead    (EX_MemRead),
        .EX_RegWrite   (EX_RegWrite),
        .EX_Rd         (EX_Rd),
        .MEM_RegWrite  (MEM_RegWrite),
        .MEM_Rd        (MEM_Rd),
        .EX_BranchTaken(EX_BranchTaken),
        .DMEM_Req      (DMEM_Req),
        .DMEM_Ack      (DMEM_Ack),
        .PC_Write      (PC_Write),
        .IF_ID_Stall   (IF_ID_Stall),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Bubble  (ID_EX_Bubble),
        .EX_MEM_Hold   (EX_MEM_Hold),
        .Mem_Timeout   (Mem_Timeout),
        .Stall_Count   (Stall_Count)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle_inputs();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_Rd = 5'd0;
        MEM_RegWrite = 1'b0; MEM_Rd = 5'd0;
        EX_BranchTaken = 1'b0; DMEM_Req = 1'b0; DMEM_Ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b0;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Flush, ID_EX_Bubble, IF_ID_Stall, EX_MEM_Hold} !== 5'b01100) begin
            n_err++;
            $display("FAIL reset_outputs: pc/flush/bub/stall/hold=%b want 01100",
                     {PC_Write, IF_ID_Flush, ID_EX_Bubble, IF_ID_Stall, EX_MEM_Hold});
        end
        tick();
        tick();
        n_cmp++;
        if (Stall_Count !== 4'd0 || Mem_Timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs: cnt=%0d tmo=%b want 0 0", Stall_Count, Mem_Timeout);
        end
        RESET = 1'b1;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Flush, ID_EX_Bubble, IF_ID_Stall, EX_MEM_Hold} !== 5'b10000) begin
            n_err++;
            $display("FAIL idle_outputs: pc/flush/bub/stall/hold=%b want 10000",
                     {PC_Write, IF_ID_Flush, ID_EX_Bubble, IF_ID_Stall, EX_MEM_Hold});
        end
        tick();
        n_cmp++;
        if (Stall_Count !== 4'd0) begin
            n_err++;
            $display("FAIL idle_count: cnt=%0d want 0", Stall_Count);
        end
    endtask

    task automatic test_data_hazard();
        do_reset();
`ifdef HAZARD_FORWARDING_EN
        EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rs = 5'd5;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, ID_EX_Bubble} !== 3'b011) begin
            n_err++;
            $display("FAIL load_use: pc/stall/bub=%b want 011", {PC_Write, IF_ID_Stall, ID_EX_Bubble});
        end
        tick();
        idle_inputs();
        // A plain ALU writer is forwarded, so no stall.
        EX_RegWrite = 1'b1; EX_Rd = 5'd5; ID_Rs = 5'd5;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, ID_EX_Bubble} !== 3'b100) begin
            n_err++;
            $display("FAIL alu_fwd: pc/stall/bub=%b want 100", {PC_Write, IF_ID_Stall, ID_EX_Bubble});
        end
        tick();
        idle_inputs();
        #2;
        n_cmp++;
        if (Stall_Count !== 4'd1) begin
            n_err++;
            $display("FAIL load_use_count: cnt=%0d want 1", Stall_Count);
        end
`else
        EX_RegWrite = 1'b1; EX_Rd = 5'd3; ID_Rt = 5'd3; ID_UsesRt = 1'b1; ID_Rs = 5'd0;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, ID_EX_Bubble} !== 3'b011) begin
            n_err++;
            $display("FAIL ex_dep: pc/stall/bub=%b want 011", {PC_Write, IF_ID_Stall, ID_EX_Bubble});
        end
        tick();
        EX_RegWrite = 1'b0; EX_Rd = 5'd0; MEM_RegWrite = 1'b1; MEM_Rd = 5'd3;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, ID_EX_Bubble} !== 3'b011) begin
            n_err++;
            $display("FAIL mem_dep: pc/stall/bub=%b want 011", {PC_Write, IF_ID_Stall, ID_EX_Bubble});
        end
        tick();
        MEM_RegWrite = 1'b0; MEM_Rd = 5'd0;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, ID_EX_Bubble} !== 3'b100) begin
            n_err++;
            $display("FAIL dep_clear: pc/stall/bub=%b want 100", {PC_Write, IF_ID_Stall, ID_EX_Bubble});
        end
        tick();
        n_cmp++;
        if (Stall_Count !== 4'd2) begin
            n_err++;
            $display("FAIL dep_count: cnt=%0d want 2", Stall_Count);
        end
`endif
    endtask

    task automatic test_match_exclusions();
        do_reset();
        // Rd=0 never matches, even against Rs=0.
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd0; ID_Rs = 5'd0;
        MEM_RegWrite = 1'b1; MEM_Rd = 5'd0;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall} !== 2'b10) begin
            n_err++;
            $display("FAIL rd_zero: pc/stall=%b want 10", {PC_Write, IF_ID_Stall});
        end
        tick();
        // Rt match ignored when the instruction does not read Rt.
        EX_Rd = 5'd9; ID_Rs = 5'd1; ID_Rt = 5'd9; ID_UsesRt = 1'b0; MEM_Rd = 5'd9;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall} !== 2'b10) begin
            n_err++;
            $display("FAIL rt_unused: pc/stall=%b want 10", {PC_Write, IF_ID_Stall});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        EX_BranchTaken = 1'b1;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd5; ID_Rs = 5'd5;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Flush, ID_EX_Bubble, IF_ID_Stall, EX_MEM_Hold} !== 5'b11100) begin
            n_err++;
            $display("FAIL branch_flush: pc/flush/bub/stall/hold=%b want 11100",
                     {PC_Write, IF_ID_Flush, ID_EX_Bubble, IF_ID_Stall, EX_MEM_Hold});
        end
        tick();
        idle_inputs();
        #2;
        n_cmp++;
        if (Stall_Count !== 4'd0 || IF_ID_Flush !== 1'b0) begin
            n_err++;
            $display("FAIL branch_after: cnt=%0d flush=%b want 0 0", Stall_Count, IF_ID_Flush);
        end
    endtask

    task automatic test_dmem_wait();
        do_reset();
        DMEM_Req = 1'b1; DMEM_Ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            EX_BranchTaken = (i == 1);
            #2;
            n_cmp++;
            if ({PC_Write, IF_ID_Stall, EX_MEM_Hold, ID_EX_Bubble, IF_ID_Flush} !== 5'b01100) begin
                n_err++;
                $display("FAIL dmem_hold[%0d]: pc/stall/hold/bub/flush=%b want 01100", i,
                         {PC_Write, IF_ID_Stall, EX_MEM_Hold, ID_EX_Bubble, IF_ID_Flush});
            end
            tick();
        end
        EX_BranchTaken = 1'b0;
        DMEM_Ack = 1'b1;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, EX_MEM_Hold} !== 3'b100) begin
            n_err++;
            $display("FAIL dmem_ack: pc/stall/hold=%b want 100", {PC_Write, IF_ID_Stall, EX_MEM_Hold});
        end
        tick();
        DMEM_Req = 1'b0; DMEM_Ack = 1'b0;
        n_cmp++;
        if (Stall_Count !== 4'd4) begin
            n_err++;
            $display("FAIL dmem_count: cnt=%0d want 4", Stall_Count);
        end
        // Back in RUN: a load-use hazard is honoured straight away.
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd7; ID_Rs = 5'd7;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, ID_EX_Bubble, EX_MEM_Hold} !== 4'b0110) begin
            n_err++;
            $display("FAIL post_ack_hazard: pc/stall/bub/hold=%b want 0110",
                     {PC_Write, IF_ID_Stall, ID_EX_Bubble, EX_MEM_Hold});
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (Stall_Count !== 4'd5) begin
            n_err++;
            $display("FAIL post_ack_count: cnt=%0d want 5", Stall_Count);
        end
    endtask

    task automatic test_same_cycle_ack();
        do_reset();
        DMEM_Req = 1'b1; DMEM_Ack = 1'b1;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, EX_MEM_Hold} !== 3'b100) begin
            n_err++;
            $display("FAIL same_ack: pc/stall/hold=%b want 100", {PC_Write, IF_ID_Stall, EX_MEM_Hold});
        end
        tick();
        idle_inputs();
        #2;
        n_cmp++;
        if (EX_MEM_Hold !== 1'b0 || Stall_Count !== 4'd0) begin
            n_err++;
            $display("FAIL same_ack_after: hold=%b cnt=%0d want 0 0", EX_MEM_Hold, Stall_Count);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        DMEM_Req = 1'b1; DMEM_Ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #2;
            n_cmp++;
            if (EX_MEM_Hold !== 1'b1 || Mem_Timeout !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_wait[%0d]: hold=%b tmo=%b want 1 0", i, EX_MEM_Hold, Mem_Timeout);
            end
            tick();
        end
        n_cmp++;
        if (Mem_Timeout !== 1'b1 || Stall_Count !== 4'd8) begin
            n_err++;
            $display("FAIL tmo_set: tmo=%b cnt=%0d want 1 8", Mem_Timeout, Stall_Count);
        end
        // A late ack must not release the error state.
        DMEM_Ack = 1'b1;
        #2;
        n_cmp++;
        if ({PC_Write, IF_ID_Stall, EX_MEM_Hold} !== 3'b011) begin
            n_err++;
            $display("FAIL err_late_ack: pc/stall/hold=%b want 011", {PC_Write, IF_ID_Stall, EX_MEM_Hold});
        end
        tick();
        idle_inputs();
        repeat (10) tick();
        n_cmp++;
        if (Stall_Count !== 4'hF || EX_MEM_Hold !== 1'b1 || Mem_Timeout !== 1'b1) begin
            n_err++;
            $display("FAIL err_saturate: cnt=%0d hold=%b tmo=%b want 15 1 1",
                     Stall_Count, EX_MEM_Hold, Mem_Timeout);
        end
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        #2;
        n_cmp++;
        if (Stall_Count !== 4'd0 || Mem_Timeout !== 1'b0 || PC_Write !== 1'b1 ||
            EX_MEM_Hold !== 1'b0) begin
            n_err++;
            $display("FAIL err_reset: cnt=%0d tmo=%b pc=%b hold=%b want 0 0 1 0",
                     Stall_Count, Mem_Timeout, PC_Write, EX_MEM_Hold);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        RESET = 1'b0;
        test_reset();
        test_data_hazard();
        test_match_exclusions();
        test_branch();
        test_dmem_wait();
        test_same_cycle_ack();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
